mdu_iter: RTL
=============

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have one parameter line: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port funct3, input, 3, RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 The block SHALL have ports rs1_val and rs2_val, input, 32, operand values read from the register file.
REQ-007 The block SHALL have port rd_num, input, 5, destination register number, captured with the operands.
REQ-008 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse that qualifies result.
REQ-010 The block SHALL have ports result (output, 32), result_rd (output, 5) and result_we (output, 1), driving the register file write_value, dstreg_num and reg_we; result_we = done AND (result_rd != 0).

Function
REQ-011 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after the 32nd step; DONE->IDLE unconditionally after one cycle.
REQ-012 On the edge that accepts start, funct3, rs1_val, rs2_val and rd_num SHALL be latched; later input changes SHALL not affect the operation.
REQ-013 start while busy SHALL be ignored, with no queuing and no error.
REQ-014 Iterative path: one shift-add (multiply) or restoring-subtract (divide) step per cycle in RUN, with a 6-bit step counter counting 0..31.
REQ-015 Latency: done SHALL be high exactly 33 cycles after the accepting edge; start may be re-accepted in the cycle after DONE.
REQ-016 Signed ops SHALL operate on magnitudes with the sign fixed at the end; MULHSU SHALL treat rs1 as signed and rs2 as unsigned.
REQ-017 MUL SHALL return the low 32 bits of the 64-bit product; MULH/MULHSU/MULHU SHALL return the high 32 bits.
REQ-018 Division by zero SHALL return quotient 0xFFFFFFFF (DIV and DIVU) and remainder = rs1_val (REM and REMU).
REQ-019 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0.
REQ-020 The remainder sign SHALL follow the dividend; the quotient SHALL truncate toward zero.
REQ-021 result and result_rd SHALL hold their value from done until the next done; result_we SHALL be low outside done.

Reset
REQ-022 rst SHALL force state IDLE and busy=0, done=0, result_we=0, result=0, result_rd=0, counter=0.
REQ-023 rst asserted mid-operation SHALL abort the operation with no done pulse; the next start after rst deasserts SHALL be accepted normally.
REQ-024 rst SHALL take priority over start on the same edge.

Configuration
REQ-025 With macro MDU_FAST_MUL_EN defined, MUL/MULH/MULHSU/MULHU SHALL use a single-cycle 64-bit multiplier: IDLE->DONE directly, done 1 cycle after the accepting edge.
REQ-026 Without MDU_FAST_MUL_EN, all multiplies SHALL be iterative per REQ-015; division SHALL always be iterative.

Structure
REQ-027 Package mdu_pkg SHALL hold the funct3 op constants, the FSM state encoding and the step count constant (32).
REQ-028 The restoring divider datapath SHALL be one sub-module, mdu_div_core (step input, quotient/remainder registers); multiply and control logic stay in mdu_iter.

Verification
REQ-029 MUL with rs1=7, rs2=0xFFFFFFFD, rd=5 -> done at cycle +33, result=0xFFFFFFEB, result_rd=5, result_we=1.
REQ-030 MULH with 0x80000000 x 0x80000000 -> result=0x40000000; MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-032 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV with rd=0 -> done=1, result_we=0.
REQ-033 start pulsed at cycle +10 of a running op -> ignored, exactly one done at +33; rst at +20 -> no done, all outputs 0, next start completes correctly.
REQ-034 With MDU_FAST_MUL_EN, MUL 3x4 -> done 1 cycle after start, result=12; DIVU 100/7 -> result=14 at +33.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit: funct3 opcodes,
// FSM state encoding, iteration count and sign-fixup helpers.
package mdu_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam int STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring unsigned divider: one quotient bit per step on magnitudes.
// Exposes next-state values so the caller can register the final result on the last step.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_nxt,
  output logic [31:0] rem_nxt
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [33:0] trial;

  always_comb begin
    // Extra guard bit keeps the borrow distinct from the partial remainder's MSB.
    trial   = {1'b0, rem_q, quo_q[31]} - {2'b00, dvs_q};
    quo_nxt = {quo_q[30:0], ~trial[33]};
    rem_nxt = trial[33] ? {rem_q[30:0], quo_q[31]} : trial[31:0];

    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      quo_d = quo_nxt;
      rem_d = rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit (32 steps per op, done one cycle after the last step).
// Define MDU_FAST_MUL_EN to complete multiplies in a single cycle with a 64-bit multiplier.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_num,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd,
  output logic            result_we
);

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_q, neg_d;
  logic [63:0]     mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [63:0]     prod_q, prod_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      result_rd_q, result_rd_d;

  logic            a_sgn, b_sgn, sa, sb, neg_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [63:0]     prod_step, prod_fix;
  logic [XLEN-1:0] mul_res, div_sel, div_res, run_res;
  logic [XLEN-1:0] quo_nxt, rem_nxt;
  logic            div_load, run_step;

  // Operand decode: magnitudes and final sign are fixed at acceptance.
  always_comb begin
    a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa    = a_sgn & rs1_val[XLEN-1];
    sb    = b_sgn & rs2_val[XLEN-1];
    mag_a = cond_neg32(rs1_val, sa);
    mag_b = cond_neg32(rs2_val, sb);
    if ((funct3 == F3_REM) || (funct3 == F3_REMU)) begin
      neg_in = sa;
    end else if (funct3[2]) begin
      // Divide by zero returns all-ones unsigned, so the quotient sign is never applied.
      neg_in = (sa ^ sb) && (rs2_val != '0);
    end else begin
      neg_in = sa ^ sb;
    end
  end

  always_comb begin
    prod_step = prod_q + (mplier_q[0] ? mcand_q : 64'd0);
    prod_fix  = cond_neg64(prod_step, neg_q);
    mul_res   = (op_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    div_sel   = ((op_q == F3_REM) || (op_q == F3_REMU)) ? rem_nxt : quo_nxt;
    div_res   = cond_neg32(div_sel, neg_q);
    run_res   = op_q[2] ? div_res : mul_res;
  end

`ifdef MDU_FAST_MUL_EN
  logic [63:0]     fast_prod;
  logic [XLEN-1:0] fast_res;
  always_comb begin
    fast_prod = cond_neg64(64'(mag_a) * 64'(mag_b), neg_in);
    fast_res  = (funct3 == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    neg_d       = neg_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_rd_d = result_rd_q;
    div_load    = 1'b0;
    run_step    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d     = funct3;
          rd_d     = rd_num;
          neg_d    = neg_in;
          mcand_d  = {32'd0, mag_a};
          mplier_d = mag_b;
          prod_d   = '0;
          div_load = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RUN;
`ifdef MDU_FAST_MUL_EN
          if (!funct3[2]) begin
            result_d    = fast_res;
            result_rd_d = rd_num;
            state_d     = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        run_step = 1'b1;
        prod_d   = prod_step;
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'(STEPS - 1)) begin
          cnt_d       = '0;
          result_d    = run_res;
          result_rd_d = rd_q;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  mdu_div_core u_div (
    .clk      (clk),
    .load     (div_load),
    .step     (run_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // Datapath registers are don't-care until loaded at acceptance.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    rd_q     <= rd_d;
    neg_q    <= neg_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    prod_q   <= prod_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      result_rd_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_rd_q <= result_rd_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_rd = result_rd_q;
  assign result_we = done && (result_rd_q != 5'd0);

endmodule
